spi_reg_master: RTL and testbench

SPI master that issues write-only register transactions to the SID SPI register slave. Accepts (address, data) write requests on a valid/ready handshake, serialises each as one 16-bit CPOL=0/CPHA=0, MSB-first frame, and paces SCLK slowly enough for a slave that 2FF-synchronises SCLK, CS_n and MOSI into its own clock domain. Used on-chip by sequencers and as the bench driver.

---
 rtl/spi_reg_master.sv | 91 +++++++++
 tb/tb_spi_reg_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// spi_reg_master: write-only SPI register master, 16-bit CPOL=0/CPHA=0 MSB-first frames {addr,5'b0,data}
// Parameters: CLK_DIV (SCLK half-period, 2..255), CS_GAP (CS_n-high cycles between frames, 3..255)
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_addr/req_data write request handshake;
//        busy (frame active or queued), done (pulse on CS_n rise after a full frame);
//        spi_clk, spi_cs_n, spi_mosi serial outputs; spi_miso unused.
// Build option: SPI_REG_MASTER_FIFO_EN adds a 4-entry request FIFO; otherwise a request is taken only in IDLE.
module spi_reg_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;
  state_t state, state_d;
  logic [7:0] phase;
  logic [3:0] bit_idx;
  logic [15:0] sh;
  logic [10:0] head;
  logic start, phase_end, miso_unused;
  assign miso_unused = spi_miso;
  assign phase_end = phase == 8'd0;
`ifdef SPI_REG_MASTER_FIFO_EN
  logic [10:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic push;
  assign req_ready = !cnt[2] && !rst;
  assign push = req_valid && req_ready;
  assign start = state == IDLE && cnt != 3'd0;
  assign head = mem[rp];
  assign busy = state != IDLE || cnt != 3'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 3'd0;
    end else begin
      wp <= push ? wp + 2'd1 : wp;
      rp <= start ? rp + 2'd1 : rp;
      cnt <= cnt + 3'(push) - 3'(start);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {req_addr, req_data};
`else
  assign req_ready = state == IDLE && !rst;
  assign start = state == IDLE && req_valid;
  assign head = {req_addr, req_data};
  assign busy = state != IDLE;
`endif
  // The IDLE cycle that launches the next frame also counts as CS_n-high time,
  // so GAP itself lasts CS_GAP-1 cycles to keep CS_n high exactly CS_GAP cycles.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? SETUP : IDLE;
      SETUP:   state_d = phase_end ? HIGH : SETUP;
      HIGH:    state_d = phase_end ? LOW : HIGH;
      LOW:     state_d = phase_end ? (bit_idx == 4'd0 ? GAP : HIGH) : LOW;
      GAP:     state_d = phase_end ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      phase <= 8'd0;
      bit_idx <= 4'd0;
      sh <= 16'd0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      phase <= state_d != state ? (state_d == GAP ? 8'(CS_GAP - 2) : 8'(CLK_DIV - 1)) : phase - 8'd1;
      done <= state == LOW && phase_end && bit_idx == 4'd0;
      bit_idx <= start ? 4'd15 : (state == LOW && phase_end) ? bit_idx - 4'd1 : bit_idx;
      sh <= start ? {head[10:8], 5'b00000, head[7:0]} : (state == HIGH && phase_end) ? {sh[14:0], 1'b0} : sh;
    end
  assign spi_cs_n = !(state == SETUP || state == HIGH || state == LOW);
  assign spi_clk = state == HIGH;
  assign spi_mosi = !spi_cs_n && sh[15];
endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: randomized/directed bench with a frame-level SPI slave model
module tb_spi_reg_master;
  localparam int CD = 4;
  localparam int GP = 4;
`ifdef SPI_REG_MASTER_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, req_valid = 0, spi_miso = 0;
  logic [2:0] req_addr = 0;
  logic [7:0] req_data = 0;
  logic req_ready, busy, done, spi_clk, spi_cs_n, spi_mosi;
  spi_reg_master #(.CLK_DIV(CD), .CS_GAP(GP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  always #5 clk = ~clk;
  int n_assert = 0, n_fail = 0;
  logic [15:0] fr_word [$];
  int fr_low [$], fr_rise [$], gaps [$];
  bit fr_done [$];
  logic [7:0] slave_regs [8] = '{default: 8'h00};
  logic [7:0] exp_regs [8] = '{default: 8'h00};
  int cur_low = 0, cur_rises = 0, hi_cnt = 0, mosi_viol = 0, done_cnt = 0, done_stray = 0, ready_viol = 0;
  logic [15:0] cur_word = 0;
  logic p_cs = 1, p_clk = 0, p_mosi = 0, p_rise = 0, rise;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Slave model: decodes each CS_n-low window from SCLK rises and commits full 16-bit frames only.
  initial forever begin
    @(negedge clk);
    rise = spi_clk && !p_clk;
    if (!spi_cs_n && p_cs) begin
      gaps.push_back(hi_cnt);
      cur_low = 0;
      cur_rises = 0;
      cur_word = 0;
    end
    if (spi_cs_n && !p_cs) begin
      fr_word.push_back(cur_word);
      fr_low.push_back(cur_low);
      fr_rise.push_back(cur_rises);
      fr_done.push_back(done);
      if (cur_rises == 16) slave_regs[cur_word[15:13]] = cur_word[7:0];
      hi_cnt = 0;
    end
    if (spi_cs_n) hi_cnt++;
    else cur_low++;
    if (rise) begin
      cur_rises++;
      cur_word = {cur_word[14:0], spi_mosi};
    end
    if (!spi_cs_n && spi_mosi !== p_mosi && (rise || p_rise)) mosi_viol++;
    if (done) done_cnt++;
    if (done && !(spi_cs_n && !p_cs)) done_stray++;
`ifndef SPI_REG_MASTER_FIFO_EN
    if (!rst && req_ready === busy) ready_viol++;
`endif
    p_cs = spi_cs_n;
    p_clk = spi_clk;
    p_mosi = spi_mosi;
    p_rise = rise;
  end
  task automatic send(input logic [2:0] a, input logic [7:0] d, input bit lat);
    int t = 0;
    @(negedge clk);
    req_valid = 1;
    req_addr = a;
    req_data = d;
    while (!req_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 0;
    if (lat)
      for (int i = 1; i <= LAT; i++) begin
        @(negedge clk);
        chk("cs_latency", spi_cs_n, (i == LAT) ? 0 : 1);
      end
  endtask
  task automatic wait_frames(input int k);
    int t = 0;
    while (fr_word.size() < k && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("frame_timeout", fr_word.size() >= k, 1);
  endtask
  task automatic check_frame(input int n, input logic [15:0] w);
    chk("word", fr_word[n], w);
    chk("cs_low_cycles", fr_low[n], 33 * CD);
    chk("sclk_rises", fr_rise[n], 16);
    chk("done_on_cs_rise", fr_done[n], 1);
  endtask
  task automatic check_busy_drop();
    repeat (GP - 2) @(negedge clk);
    chk("busy_last_gap", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    int nf;
    logic [15:0] exp_w [8];
    logic [7:0] d;
    #1 chk("async_rst_cs_n", spi_cs_n, 1);
    @(negedge clk);
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    rst = 0;
    nf = 0;
    send(3'd0, 8'h5A, 1);
    exp_regs[0] = 8'h5A;
    wait_frames(nf + 1);
    check_frame(nf, 16'h005A);
    nf++;
    check_busy_drop();
    chk("slave_freq_lo", slave_regs[0], exp_regs[0]);
    chk("done_count_1", done_cnt, 1);
    send(3'd6, 8'hA5, 1);
    exp_regs[6] = 8'hA5;
    wait_frames(nf + 1);
    check_frame(nf, 16'hC0A5);
    nf++;
    chk("slave_r6", slave_regs[6], exp_regs[6]);
    repeat (GP + 2) @(negedge clk);
    send(3'd1, 8'hFF, 1);
    begin
      int t = 0;
      while (cur_rises < 9 && t < 2000) begin
        @(posedge clk);
        t++;
      end
      chk("reach_bit7", cur_rises, 9);
    end
    #2 rst = 1;
    #1 chk("midrst_cs_n", spi_cs_n, 1);
    chk("midrst_sclk", spi_clk, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    wait_frames(nf + 1);
    chk("aborted_rises", fr_rise[nf], 9);
    chk("aborted_no_done", fr_done[nf], 0);
    nf++;
    chk("slave_freq_hi_kept", slave_regs[1], exp_regs[1]);
    chk("done_count_2", done_cnt, 2);
    send(3'd1, 8'h3C, 1);
    exp_regs[1] = 8'h3C;
    wait_frames(nf + 1);
    check_frame(nf, 16'h203C);
    nf++;
    chk("slave_freq_hi", slave_regs[1], exp_regs[1]);
    for (int a = 0; a < 8; a++) begin
      d = {5'($urandom_range(0, 31)), 3'(a)};
      exp_regs[a] = d;
      exp_w[a] = {3'(a), 5'b00000, d};
      send(3'(a), d, 0);
    end
    wait_frames(nf + 8);
    for (int i = 0; i < 8; i++) begin
      check_frame(nf + i, exp_w[i]);
      if (i > 0) chk("cs_gap", gaps[nf + i], GP);
    end
    nf += 8;
    check_busy_drop();
    for (int a = 0; a < 8; a++) chk("slave_reg", slave_regs[a], exp_regs[a]);
    chk("mosi_stable_at_rise", mosi_viol, 0);
    chk("done_stray", done_stray, 0);
    chk("ready_while_busy", ready_viol, 0);
    chk("done_total", done_cnt, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
